// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: issues one load or store at a time, waits for
// memAck with a bounded wait, and produces single-cycle register-file write pulses.
module mem_wb_stage #(
    parameter int         DBITS               = 32,
    parameter int         REG_INDEX_BIT_WIDTH = 4,
    parameter int         TIMEOUT             = 64,
    parameter logic [1:0] MUL_ALU             = 2'b00,
    parameter logic [1:0] MUL_MEM             = 2'b01,
    parameter logic [1:0] MUL_PC              = 2'b10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inRegWrEn,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] inWrtIndex,
    input  logic [1:0]                     inMulSel,
    input  logic [DBITS-1:0]               inAluOut,
    input  logic [DBITS-1:0]               inData2Out,
    input  logic [DBITS-1:0]               inPC,
    input  logic                           inIsLoad,
    input  logic                           inIsStore,
    output logic                           memReq,
    output logic                           memWe,
    output logic [DBITS-1:0]               memAddr,
    output logic [DBITS-1:0]               memWdata,
    input  logic [DBITS-1:0]               memRdata,
    input  logic                           memAck,
    output logic                           wbEn,
    output logic [REG_INDEX_BIT_WIDTH-1:0] wbIndex,
    output logic [DBITS-1:0]               wbData,
    output logic                           busy,
    output logic                           memErr
);

    typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST} state_e;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e                         state_q;
    logic [CW-1:0]                  cnt_q;
    logic [REG_INDEX_BIT_WIDTH-1:0] idx_q;
    logic                           wren_q;
    logic [DBITS-1:0]               alu_wb_d;
    logic                           is_mem;
    logic                           misaligned;

    assign busy       = (state_q != IDLE);
    assign is_mem     = inIsLoad | inIsStore;
    assign misaligned = (inAluOut[1:0] != 2'b00);

    // MUL_MEM on a non-memory instruction and the unused code 2'b11 both fall back to the ALU result
    always_comb begin
        alu_wb_d = inAluOut;
        case (inMulSel)
            MUL_PC:           alu_wb_d = inPC;
            MUL_ALU, MUL_MEM: alu_wb_d = inAluOut;
            default:          alu_wb_d = inAluOut;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wren_q   <= 1'b0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            wbEn     <= 1'b0;
            wbIndex  <= '0;
            wbData   <= '0;
            memErr   <= 1'b0;
        end else begin
            wbEn <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_mem && misaligned) begin
                        memErr <= 1'b1;
                    end else if (inIsLoad) begin
                        memReq  <= 1'b1;
                        memWe   <= 1'b0;
                        memAddr <= inAluOut;
                        idx_q   <= inWrtIndex;
                        wren_q  <= inRegWrEn;
                        cnt_q   <= '0;
                        state_q <= WAIT_LD;
                    end else if (inIsStore) begin
                        memReq   <= 1'b1;
                        memWe    <= 1'b1;
                        memAddr  <= inAluOut;
                        memWdata <= inData2Out;
                        cnt_q    <= '0;
                        state_q  <= WAIT_ST;
                    end else if (inRegWrEn) begin
                        wbEn    <= 1'b1;
                        wbIndex <= inWrtIndex;
                        wbData  <= alu_wb_d;
                    end
                end
                WAIT_LD, WAIT_ST: begin
                    if (memAck) begin
                        memReq  <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == WAIT_LD && wren_q) begin
                            wbEn    <= 1'b1;
                            wbIndex <= idx_q;
                            wbData  <= memRdata;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // Acknowledge never arrived: drop the request and flag it
                        memReq  <= 1'b0;
                        memErr  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inRegWrEn;
    logic [3:0]  inWrtIndex;
    logic [1:0]  inMulSel;
    logic [31:0] inAluOut, inData2Out, inPC;
    logic        inIsLoad, inIsStore;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memAck;
    logic        wbEn;
    logic [3:0]  wbIndex;
    logic [31:0] wbData;
    logic        busy, memErr;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .inRegWrEn(inRegWrEn), .inWrtIndex(inWrtIndex), .inMulSel(inMulSel),
        .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
        .inIsLoad(inIsLoad), .inIsStore(inIsStore),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .wbEn(wbEn), .wbIndex(wbIndex), .wbData(wbData),
        .busy(busy), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        inRegWrEn = 0; inWrtIndex = 0; inMulSel = 0; inAluOut = 0;
        inData2Out = 0; inPC = 0; inIsLoad = 0; inIsStore = 0;
    endtask

    task automatic set_instr(input logic wr, input logic [3:0] idx, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
                             input logic ld, input logic st);
        inRegWrEn = wr; inWrtIndex = idx; inMulSel = sel; inAluOut = alu;
        inData2Out = d2; inPC = pc; inIsLoad = ld; inIsStore = st;
    endtask

    task automatic do_reset();
        reset = 1; memAck = 0; memRdata = 0; set_nop();
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({memReq, memWe, wbEn, memErr, busy} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {memReq, memWe, wbEn, memErr, busy}); else n_pass++;
        n_checks++; if (memAddr !== 32'h0 || memWdata !== 32'h0) $display("FAIL reset_mem got %h/%h exp 0/0", memAddr, memWdata); else n_pass++;
        n_checks++; if (wbIndex !== 4'h0 || wbData !== 32'h0) $display("FAIL reset_wb got %h/%h exp 0/0", wbIndex, wbData); else n_pass++;
    endtask

    task automatic test_alu();
        set_instr(1, 4'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 0, 0);
        tick();
        set_nop();
        n_checks++; if ({wbEn, wbIndex, busy} !== {1'b1, 4'd5, 1'b0}) $display("FAIL alu_ctrl got en=%b idx=%0d busy=%b exp 1/5/0", wbEn, wbIndex, busy); else n_pass++;
        n_checks++; if (wbData !== 32'h1234) $display("FAIL alu_data got %h exp 00001234", wbData); else n_pass++;
        tick();
        n_checks++; if (wbEn !== 1'b0 || wbData !== 32'h1234) $display("FAIL alu_pulse got en=%b data=%h exp 0/00001234", wbEn, wbData); else n_pass++;
    endtask

    task automatic test_load();
        set_instr(1, 4'd3, 2'b01, 32'h100, 32'h0, 32'h0, 1, 0);
        tick();
        n_checks++; if ({memReq, memWe, busy} !== 3'b101 || memAddr !== 32'h100) $display("FAIL load_req got req/we/busy=%b addr=%h exp 101/00000100", {memReq, memWe, busy}, memAddr); else n_pass++;
        tick(); tick(); tick();
        memAck = 1; memRdata = 32'hCAFEF00D; set_nop();
        n_checks++; if (busy !== 1'b1 || memReq !== 1'b1) $display("FAIL load_ackcyc got busy=%b req=%b exp 1/1", busy, memReq); else n_pass++;
        tick();
        memAck = 0; memRdata = 0;
        n_checks++; if ({wbEn, wbIndex, memReq, busy} !== {1'b1, 4'd3, 1'b0, 1'b0}) $display("FAIL load_wb got en=%b idx=%0d req=%b busy=%b exp 1/3/0/0", wbEn, wbIndex, memReq, busy); else n_pass++;
        n_checks++; if (wbData !== 32'hCAFEF00D) $display("FAIL load_data got %h exp cafef00d", wbData); else n_pass++;
        tick();
        n_checks++; if (wbEn !== 1'b0) $display("FAIL load_pulse got %b exp 0", wbEn); else n_pass++;
    endtask

    task automatic test_store();
        int bad = 0;
        set_instr(1, 4'd9, 2'b00, 32'h20, 32'hA5A5A5A5, 32'h0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h20 || memWdata !== 32'hA5A5A5A5 || wbEn !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad != 0) $display("FAIL store_hold got %0d bad cycles exp 0", bad); else n_pass++;
        memAck = 1; set_nop();
        tick();
        memAck = 0;
        n_checks++; if ({memReq, wbEn, busy} !== 3'b000) $display("FAIL store_done got req/wb/busy=%b exp 000", {memReq, wbEn, busy}); else n_pass++;
    endtask

    task automatic test_jal();
        set_instr(1, 4'd15, 2'b10, 32'h999, 32'h0, 32'h44, 0, 0);
        tick();
        set_nop();
        n_checks++; if ({wbEn, wbIndex} !== {1'b1, 4'd15} || wbData !== 32'h44) $display("FAIL jal got en=%b idx=%0d data=%h exp 1/15/00000044", wbEn, wbIndex, wbData); else n_pass++;
        tick();
    endtask

    task automatic test_misalign();
        do_reset();
        set_instr(1, 4'd2, 2'b01, 32'h102, 32'h0, 32'h0, 1, 0);
        tick();
        set_nop();
        n_checks++; if ({memReq, wbEn, busy, memErr} !== 4'b0001) $display("FAIL misalign got req/wb/busy/err=%b exp 0001", {memReq, wbEn, busy, memErr}); else n_pass++;
        tick(); tick();
        n_checks++; if (memErr !== 1'b1) $display("FAIL err_sticky got %b exp 1", memErr); else n_pass++;
    endtask

    task automatic test_timeout();
        int hi = 0;
        int saw_wb = 0;
        do_reset();
        set_instr(1, 4'd7, 2'b01, 32'h200, 32'h0, 32'h0, 1, 0);
        tick();
        for (int i = 0; i < 200 && memReq === 1'b1; i++) begin
            hi++;
            if (wbEn !== 1'b0) saw_wb++;
            tick();
        end
        set_nop();
        n_checks++; if (hi != 64) $display("FAIL timeout_len got %0d exp 64", hi); else n_pass++;
        n_checks++; if ({memErr, busy, wbEn, saw_wb != 0} !== 4'b1000) $display("FAIL timeout_state got err/busy/wb/sawwb=%b exp 1000", {memErr, busy, wbEn, saw_wb != 0}); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        set_instr(1, 4'd4, 2'b01, 32'h40, 32'h0, 32'h0, 1, 0);
        tick(); tick();
        reset = 1; memAck = 1; memRdata = 32'h12345678; set_nop();
        tick();
        reset = 0;
        n_checks++; if ({memReq, busy} !== 2'b00) $display("FAIL rstwait_req got req/busy=%b exp 00", {memReq, busy}); else n_pass++;
        tick();
        memAck = 0;
        n_checks++; if ({wbEn, memReq, memErr} !== 3'b000 || wbData !== 32'h0) $display("FAIL rstwait_wb got en/req/err=%b data=%h exp 000/0", {wbEn, memReq, memErr}, wbData); else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_instr(1, 4'd1, 2'b11, 32'hAAAA0001, 32'h0, 32'h77, 0, 0);
        tick();
        set_instr(1, 4'd0, 2'b10, 32'h5, 32'h0, 32'hBEEF0000, 0, 0);
        n_checks++; if ({wbEn, wbIndex} !== {1'b1, 4'd1} || wbData !== 32'hAAAA0001) $display("FAIL b2b_first got en=%b idx=%0d data=%h exp 1/1/aaaa0001", wbEn, wbIndex, wbData); else n_pass++;
        tick();
        set_instr(0, 4'd6, 2'b00, 32'h9, 32'h0, 32'h0, 0, 0);
        n_checks++; if ({wbEn, wbIndex} !== {1'b1, 4'd0} || wbData !== 32'hBEEF0000) $display("FAIL b2b_second got en=%b idx=%0d data=%h exp 1/0/beef0000", wbEn, wbIndex, wbData); else n_pass++;
        tick();
        set_nop();
        n_checks++; if (wbEn !== 1'b0 || wbData !== 32'hBEEF0000) $display("FAIL b2b_nowr got en=%b data=%h exp 0/beef0000", wbEn, wbData); else n_pass++;
        tick();
    endtask

    // Transaction-level model: each instruction resolves to an expected memory
    // request (if any) and an expected register write, tracked as last-written values.
    task automatic test_random();
        logic        exp_err = 0;
        logic [3:0]  last_idx = 0;
        logic [31:0] last_data = 0;
        int          errs = 0;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic        wr   = 1'($urandom_range(0, 3) != 0);
            logic [3:0]  idx  = 4'($urandom);
            logic [1:0]  sel  = 2'($urandom);
            logic [31:0] alu  = $urandom;
            logic [31:0] d2   = $urandom;
            logic [31:0] pc   = $urandom;
            int          kind = $urandom_range(0, 3);
            logic        ld   = (kind == 1 || kind == 3);
            logic        st   = (kind == 2 || kind == 3);
            if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
            set_instr(wr, idx, sel, alu, d2, pc, ld, st);
            tick();
            if ((ld || st) && alu[1:0] != 2'b00) begin
                exp_err = 1;
                if (memReq !== 1'b0 || wbEn !== 1'b0 || busy !== 1'b0 || wbIndex !== last_idx || wbData !== last_data) errs++;
            end else if (ld || st) begin
                int          dly   = $urandom_range(0, 5);
                logic [31:0] rdata = $urandom;
                if (memReq !== 1'b1 || memWe !== !ld || memAddr !== alu || busy !== 1'b1 || wbEn !== 1'b0) errs++;
                if (!ld && memWdata !== d2) errs++;
                for (int i = 0; i < dly; i++) begin
                    tick();
                    if (memReq !== 1'b1 || busy !== 1'b1 || wbEn !== 1'b0) errs++;
                end
                memAck = 1; memRdata = rdata;
                tick();
                memAck = 0; memRdata = $urandom;
                if (ld && wr) begin
                    last_idx = idx; last_data = rdata;
                end
                if (memReq !== 1'b0 || busy !== 1'b0 || wbEn !== (ld && wr)) errs++;
            end else begin
                if (wr) begin
                    last_idx = idx;
                    last_data = (sel == 2'b10) ? pc : alu;
                end
                if (wbEn !== wr || busy !== 1'b0 || memReq !== 1'b0) errs++;
            end
            if (wbIndex !== last_idx || wbData !== last_data || memErr !== exp_err) errs++;
            if (errs != 0 && n_checks >= 0) begin
                n_checks++;
                $display("FAIL random_step n=%0d got idx=%0d data=%h err=%b exp idx=%0d data=%h err=%b", n, wbIndex, wbData, memErr, last_idx, last_data, exp_err);
                errs = 0;
                n = 300;
            end
        end
        set_nop();
        n_checks++; if (memErr !== exp_err || wbData !== last_data) $display("FAIL random_final got err=%b data=%h exp %b/%h", memErr, wbData, exp_err, last_data); else n_pass++;
    endtask

    initial begin
        reset = 1; memAck = 0; memRdata = 0; set_nop();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jal();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
